// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder controller around a 1-bit full_adder cell
// Optional OVF output enabled by defining SERIAL_ADD_OVF_EN.

module full_adder (
   input  logic [1:0] A,
   input  logic       C_in,
   output logic       S,
   output logic       C_out
);
   assign S     = A[1] ^ A[0] ^ C_in;
   assign C_out = (A[1] & A[0]) | (C_in & (A[1] ^ A[0]));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C_out
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             OVF
`endif
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry_q;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;
   logic [WIDTH-1:0] sum_next;

   full_adder u_fa (
      .A     ({a_sh[0], b_sh[0]}),
      .C_in  (carry_q),
      .S     (fa_s),
      .C_out (fa_c)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));
   assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};
   assign busy     = (state == RUN);
   assign done     = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         S       <= '0;
         C_out   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         OVF     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh    <= A;
                  b_sh    <= B;
                  carry_q <= C_in;
                  cnt     <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               sum_sh  <= sum_next;
               carry_q <= fa_c;
               if (last_bit) begin
                  // Outputs only ever see the completed sum.
                  state <= DONE;
                  S     <= sum_next;
                  C_out <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                  OVF   <= carry_q ^ fa_c;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl (WIDTH=8)

module tb_serial_adder_ctrl;
   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       C_in;
   logic       busy;
   logic       done;
   logic [7:0] S;
   logic       C_out;
`ifdef SERIAL_ADD_OVF_EN
   logic       OVF;
`endif

   int         checks = 0;
   int         passes = 0;
   logic [7:0] last_s = 8'h00;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .C_in  (C_in),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .C_out (C_out)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .OVF   (OVF)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] exp_s, input logic exp_c, input logic exp_ovf,
                        input string tag);
      int   bc;
      logic gd;
      @(negedge clk);
      A = a; B = b; C_in = cin; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      bc = 0;
      gd = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            gd = 1'b1;
            break;
         end
         if (busy) begin
            bc++;
            if (bc == 4) chk({tag, "_s_hold"}, S, last_s);
         end
      end
      chk({tag, "_done"}, gd, 1);
      chk({tag, "_busy_cycles"}, bc, 8);
      chk({tag, "_s"}, S, exp_s);
      chk({tag, "_cout"}, C_out, exp_c);
`ifdef SERIAL_ADD_OVF_EN
      chk({tag, "_ovf"}, OVF, exp_ovf);
`else
      if (exp_ovf === 1'bx) chk({tag, "_ovf_x"}, 0, 1);
`endif
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      last_s = exp_s;
   endtask

   initial begin
      int   bc;
      logic gd;
      rst_n = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; C_in = 1'b0;

      // 1. async reset, no clock edge yet
      #1 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_s", S, 8'h00);
      chk("rst_cout", C_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 2-4. basic sums
      do_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "op_0f_01");
      do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "op_ff_ff_c");
      do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "op_7f_01");
      do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "op_ff_01");

      // 5. held start, operands scrambled during RUN
      @(negedge clk);
      A = 8'h12; B = 8'h34; C_in = 1'b0; start = 1'b1;
      gd = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            gd = 1'b1;
            break;
         end
         A = 8'($urandom); B = 8'($urandom); C_in = 1'($urandom);
      end
      chk("held_done", gd, 1);
      chk("held_s", S, 8'h46);
      chk("held_cout", C_out, 0);
      A = 8'h20; B = 8'h22; C_in = 1'b0;
      @(negedge clk);
      chk("held_idle_busy", busy, 0);
      chk("held_idle_done", done, 0);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("held_restart_busy", busy, 1);
      gd = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            gd = 1'b1;
            break;
         end
      end
      chk("held2_done", gd, 1);
      chk("held2_s", S, 8'h42);
      @(negedge clk);

      // 6. reset mid-RUN aborts the op
      A = 8'hFF; B = 8'h01; C_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      bc = 0;
      for (int i = 0; i < 20 && bc < 4; i++) begin
         @(negedge clk);
         if (busy) bc++;
      end
      chk("abort_reached", bc, 4);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_s", S, 8'h00);
      chk("abort_cout", C_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      gd = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) gd = 1'b1;
      end
      chk("abort_no_done", gd, 0);
      last_s = 8'h00;
      do_op(8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, "op_03_05");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
